// File: rtl/board_write_ctrl.sv
// Write-side controller for the Go board state RAM: clear sweep, checked placement, checked removal.
// Optional stone counters are enabled with `define BOARD_STONE_COUNT_EN.
module board_write_ctrl #(
  parameter int ADDR_W = 6,
  parameter int DEPTH  = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_req,
  input  logic              place_valid,
  output logic              place_ready,
  input  logic [ADDR_W-1:0] place_addr,
  input  logic [1:0]        place_color,
  input  logic              remove_valid,
  output logic              remove_ready,
  input  logic [ADDR_W-1:0] remove_addr,
  output logic              done,
  output logic              err,
  output logic              busy,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [1:0]        wr_data,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [1:0]        rd_data
`ifdef BOARD_STONE_COUNT_EN
  ,
  output logic [ADDR_W:0]   black_count,
  output logic [ADDR_W:0]   white_count
`endif
);

  typedef enum logic [2:0] {
    CLEAR = 3'd0,
    IDLE  = 3'd1,
    CHECK = 3'd2,
    WRITE = 3'd3,
    RESP  = 3'd4
  } state_t;

  // idx is one bit wider so the sweep can mark "last cell issued" with idx == DEPTH
  localparam logic [ADDR_W:0] SWEEP_END = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] IDX_ONE   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0] IDX_ZERO  = (ADDR_W+1)'(0);

  state_t              state_r, state_s;
  logic [ADDR_W:0]     idx_r, idx_s;
  logic [ADDR_W-1:0]   req_addr_r, req_addr_s;
  logic                req_rm_r, req_rm_s;
  logic [1:0]          req_color_r, req_color_s;
  logic                legal_s;
  logic                wr_en_s, done_s, err_s, busy_s;
  logic [ADDR_W-1:0]   wr_addr_s, rd_addr_s;
  logic [1:0]          wr_data_s;

  // next-state, next registered outputs and the combinational ready handshake
  always_comb begin
    state_s      = state_r;
    idx_s        = idx_r;
    req_addr_s   = req_addr_r;
    req_rm_s     = req_rm_r;
    req_color_s  = req_color_r;
    legal_s      = 1'b0;
    wr_en_s      = 1'b0;
    wr_addr_s    = wr_addr;
    wr_data_s    = 2'b00;
    rd_addr_s    = rd_addr;
    done_s       = 1'b0;
    err_s        = 1'b0;
    busy_s       = 1'b1;
    place_ready  = 1'b0;
    remove_ready = 1'b0;
    case (state_r)
      CLEAR: begin
        if (idx_r == SWEEP_END) begin
          state_s = IDLE;
        end else begin
          wr_en_s   = 1'b1;
          wr_addr_s = idx_r[ADDR_W-1:0];
          idx_s     = idx_r + IDX_ONE;
        end
      end
      IDLE: begin
        remove_ready = ~clear_req;
        place_ready  = ~clear_req & ~remove_valid;
        if (remove_valid && remove_ready) begin
          req_addr_s  = remove_addr;
          req_rm_s    = 1'b1;
          req_color_s = 2'b00;
          rd_addr_s   = remove_addr;
          state_s     = CHECK;
        end else if (place_valid && place_ready) begin
          req_addr_s  = place_addr;
          req_rm_s    = 1'b0;
          req_color_s = place_color;
          rd_addr_s   = place_addr;
          state_s     = CHECK;
        end else begin
          state_s = IDLE;
        end
      end
      CHECK: begin
        if (req_rm_r) begin
          legal_s = (rd_data != 2'b00);
        end else begin
          legal_s = (rd_data == 2'b00) && ((req_color_r == 2'b01) || (req_color_r == 2'b10));
        end
        // removes latch color 00, so wr_data is the latched color in both cases
        if (legal_s) begin
          state_s   = WRITE;
          wr_en_s   = 1'b1;
          wr_addr_s = req_addr_r;
          wr_data_s = req_color_r;
        end else begin
          state_s = RESP;
          done_s  = 1'b1;
          err_s   = 1'b1;
        end
      end
      WRITE: begin
        state_s = RESP;
        done_s  = 1'b1;
      end
      RESP: begin
        state_s = IDLE;
      end
      default: begin
        state_s = CLEAR;
        idx_s   = IDX_ZERO;
      end
    endcase
    if (clear_req) begin
      state_s = CLEAR;
      idx_s   = IDX_ZERO;
      wr_en_s = 1'b0;
      done_s  = 1'b0;
      err_s   = 1'b0;
      busy_s  = 1'b1;
    end else begin
      busy_s = (state_s != IDLE);
    end
  end

  // state, request latch and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= CLEAR;
      idx_r       <= IDX_ZERO;
      req_addr_r  <= {ADDR_W{1'b0}};
      req_rm_r    <= 1'b0;
      req_color_r <= 2'b00;
      wr_en       <= 1'b0;
      wr_addr     <= {ADDR_W{1'b0}};
      wr_data     <= 2'b00;
      rd_addr     <= {ADDR_W{1'b0}};
      done        <= 1'b0;
      err         <= 1'b0;
      busy        <= 1'b1;
    end else begin
      state_r     <= state_s;
      idx_r       <= idx_s;
      req_addr_r  <= req_addr_s;
      req_rm_r    <= req_rm_s;
      req_color_r <= req_color_s;
      wr_en       <= wr_en_s;
      wr_addr     <= wr_addr_s;
      wr_data     <= wr_data_s;
      rd_addr     <= rd_addr_s;
      done        <= done_s;
      err         <= err_s;
      busy        <= busy_s;
    end
  end

`ifdef BOARD_STONE_COUNT_EN
  logic [1:0] old_r;

  // stone counters, updated on the WRITE cycle and saturating at 0 and DEPTH
  always_ff @(posedge clk) begin
    if (rst) begin
      old_r       <= 2'b00;
      black_count <= IDX_ZERO;
      white_count <= IDX_ZERO;
    end else if (clear_req) begin
      old_r       <= 2'b00;
      black_count <= IDX_ZERO;
      white_count <= IDX_ZERO;
    end else begin
      if (state_r == CHECK) begin
        old_r <= rd_data;
      end
      if (state_r == WRITE) begin
        if (!req_rm_r) begin
          if ((req_color_r == 2'b01) && (black_count < SWEEP_END)) begin
            black_count <= black_count + IDX_ONE;
          end else if ((req_color_r == 2'b10) && (white_count < SWEEP_END)) begin
            white_count <= white_count + IDX_ONE;
          end
        end else begin
          if ((old_r == 2'b01) && (black_count != IDX_ZERO)) begin
            black_count <= black_count - IDX_ONE;
          end else if ((old_r == 2'b10) && (white_count != IDX_ZERO)) begin
            white_count <= white_count - IDX_ONE;
          end
        end
      end
    end
  end
`endif

endmodule
